// File: rtl/window_fetch_ctrl.sv
// window_fetch_ctrl: steers pixel lines round-robin into four line buffers
// and issues 3x3 windows once three full lines are held.
module window_fetch_ctrl #(
  parameter int LINE_W = 512
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_valid,
  output logic [7:0]  o_lb_wr_data,
  output logic [3:0]  o_lb_wr_valid,
  input  logic [23:0] i_lb0_data,
  input  logic [23:0] i_lb1_data,
  input  logic [23:0] i_lb2_data,
  input  logic [23:0] i_lb3_data,
  output logic [3:0]  o_lb_rd,
  input  logic        i_rd_en,
  output logic [71:0] o_window,
  output logic        o_window_valid,
  output logic        o_intr,
  output logic        o_full,
  output logic        o_overflow
);

  localparam int CW = $clog2(LINE_W);
  localparam int FW = $clog2(4 * LINE_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(LINE_W - 1);
  localparam logic [FW-1:0] FULL_LVL = FW'(4 * LINE_W);
  localparam logic [FW-1:0] RD_LVL = FW'(3 * LINE_W);

  typedef enum logic {IDLE, READ} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic [1:0]    wr_sel, rd_sel;
  logic [FW-1:0] fill;
  logic          wr_acc, rd_cyc, rd_last;
  logic [23:0]   lb [4];

  function automatic logic [3:0] onehot(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

  assign o_full  = (fill == FULL_LVL);
  assign wr_acc  = i_pixel_valid & ~o_full;
  assign rd_cyc  = (state == READ) & i_rd_en;
  assign rd_last = rd_cyc & (rd_cnt == LAST);

  assign o_lb_wr_data  = i_pixel_data;
  assign o_lb_wr_valid = wr_acc ? onehot(wr_sel) : 4'b0000;

  // Three consecutive buffers (mod 4) are read in lockstep.
  assign o_lb_rd = rd_cyc ? (onehot(rd_sel)
                           | onehot(rd_sel + 2'd1)
                           | onehot(rd_sel + 2'd2)) : 4'b0000;

  assign lb[0] = i_lb0_data;
  assign lb[1] = i_lb1_data;
  assign lb[2] = i_lb2_data;
  assign lb[3] = i_lb3_data;

  assign o_window = {lb[rd_sel], lb[rd_sel + 2'd1], lb[rd_sel + 2'd2]};
  assign o_window_valid = rd_cyc;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (fill >= RD_LVL) state_nxt = READ;
      READ: if (rd_last) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_cnt <= '0;
      wr_sel <= '0;
    end else if (wr_acc) begin
      if (wr_cnt == LAST) begin
        wr_cnt <= '0;
        wr_sel <= wr_sel + 2'd1;
      end else begin
        wr_cnt <= wr_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_cnt <= '0;
      rd_sel <= '0;
    end else if (rd_cyc) begin
      if (rd_last) begin
        rd_cnt <= '0;
        rd_sel <= rd_sel + 2'd1;
      end else begin
        rd_cnt <= rd_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fill <= '0;
    end else begin
      unique case ({wr_acc, rd_cyc})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_intr     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_intr <= rd_last;
      if (i_pixel_valid & o_full) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// tb_window_fetch_ctrl: line-buffer model plus window scoreboard
// for window_fetch_ctrl.
module tb_window_fetch_ctrl;

  localparam int LW = 512;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_pixel_data = '0;
  logic        i_pixel_valid = 1'b0;
  logic [7:0]  o_lb_wr_data;
  logic [3:0]  o_lb_wr_valid;
  logic [23:0] lbd [4];
  logic [3:0]  o_lb_rd;
  logic        i_rd_en = 1'b1;
  logic [71:0] o_window;
  logic        o_window_valid;
  logic        o_intr;
  logic        o_full;
  logic        o_overflow;

  window_fetch_ctrl #(.LINE_W(LW)) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_pixel_data(i_pixel_data),
    .i_pixel_valid(i_pixel_valid),
    .o_lb_wr_data(o_lb_wr_data),
    .o_lb_wr_valid(o_lb_wr_valid),
    .i_lb0_data(lbd[0]),
    .i_lb1_data(lbd[1]),
    .i_lb2_data(lbd[2]),
    .i_lb3_data(lbd[3]),
    .o_lb_rd(o_lb_rd),
    .i_rd_en(i_rd_en),
    .o_window(o_window),
    .o_window_valid(o_window_valid),
    .o_intr(o_intr),
    .o_full(o_full),
    .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Line buffer model: write pointer, read pointer, 3-pixel output.
  logic [7:0] mem [4][LW];
  logic [8:0] wp [4];
  logic [8:0] rp [4];

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int n = 0; n < 4; n++) begin
        wp[n] <= '0;
        rp[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (o_lb_wr_valid[n]) begin
          mem[n][wp[n]] <= o_lb_wr_data;
          wp[n] <= wp[n] + 9'd1;
        end
        if (o_lb_rd[n]) rp[n] <= rp[n] + 9'd1;
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 4; n++)
      lbd[n] = {mem[n][rp[n]], mem[n][rp[n] + 9'd1], mem[n][rp[n] + 9'd2]};
  end

  typedef struct {
    logic [71:0] win;
    logic [3:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   epoch = 0;
  int   win_in_set = 0;
  int   total_win = 0;
  bit   intr_due = 1'b0;

  task automatic chk(input string tag, input logic [71:0] got,
                     input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int l, input int c);
    int m;
    m = (epoch == 0 && l < 3) ? 0 : 37 * l + 91 * epoch;
    return 8'((c + m) & 255);
  endfunction

  function automatic logic [23:0] row(input int l, input int c);
    return {pix(l, c), pix(l, (c + 1) % LW), pix(l, (c + 2) % LW)};
  endfunction

  function automatic logic [3:0] oh(input int s);
    logic [3:0] r;
    r = 4'b0001 << (s % 4);
    return r;
  endfunction

  task automatic drive_line(input int l);
    exp_t e;
    for (int c = 0; c < LW; c++) begin
      @(posedge i_clk);
      #1;
      i_pixel_valid = 1'b1;
      i_pixel_data = pix(l, c);
      @(negedge i_clk);
      if (c == 0 || c == LW - 1) chk("wr_valid", o_lb_wr_valid, oh(l));
    end
    if (l >= 2) begin
      for (int c = 0; c < LW; c++) begin
        e.win = {row(l - 2, c), row(l - 1, c), row(l, c)};
        e.rd = oh(l - 2) | oh(l - 1) | oh(l);
        sb.push_back(e);
      end
    end
    @(posedge i_clk);
    #1;
    i_pixel_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 4000 && sb.size() != 0; i++) @(posedge i_clk);
    repeat (4) @(posedge i_clk);
    chk(tag, 72'(sb.size()), 72'd0);
  endtask

  // Monitor: compares every issued window and checks interrupt timing.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        if (intr_due || o_intr) chk("intr", o_intr, intr_due);
        intr_due = 1'b0;
        if (!o_window_valid) chk("rd_idle", o_lb_rd, 4'b0000);
        if (o_window_valid) begin
          total_win++;
          if (sb.size() == 0) begin
            chk("sb_empty", 72'd0, 72'd1);
          end else begin
            e = sb.pop_front();
            chk("window", o_window, e.win);
            chk("lb_rd", o_lb_rd, e.rd);
          end
          win_in_set++;
          if (win_in_set == LW) begin
            win_in_set = 0;
            intr_due = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_lb_rd", o_lb_rd, 4'b0000);
    chk("rst_wvalid", o_window_valid, 1'b0);
    chk("rst_intr", o_intr, 1'b0);
    chk("rst_ovf", o_overflow, 1'b0);
    chk("rst_full", o_full, 1'b0);
    chk("rst_wr", o_lb_wr_valid, 4'b0000);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // Eight lines with blanking: fill, concurrent write, selector wrap.
    for (int l = 0; l < 8; l++) begin
      drive_line(l);
      if (l == 2) begin
        @(negedge i_clk);
        chk("rd_lat0", o_window_valid, 1'b0);
        @(negedge i_clk);
        chk("rd_lat1", o_window_valid, 1'b1);
        chk("win0", o_window, 72'h000102_000102_000102);
        repeat (62) @(posedge i_clk);
      end else begin
        repeat (64) @(posedge i_clk);
      end
    end
    wait_drain("drain_a");
    chk("wins_a", 72'(total_win), 72'(6 * LW));
    chk("ovf_a", o_overflow, 1'b0);

    // Stall: toggle read enable every cycle for a whole line of windows.
    drive_line(8);
    for (int i = 0; i < 3000 && sb.size() != 0; i++) begin
      @(posedge i_clk);
      #1;
      i_rd_en = ~i_rd_en;
    end
    @(posedge i_clk);
    #1;
    i_rd_en = 1'b1;
    repeat (4) @(posedge i_clk);
    chk("drain_b", 72'(sb.size()), 72'd0);
    chk("wins_b", 72'(total_win), 72'(7 * LW));

    // Overflow: stop reading and fill to 2048, then one extra pixel.
    @(posedge i_clk);
    #1;
    i_rd_en = 1'b0;
    drive_line(9);
    drive_line(10);
    @(negedge i_clk);
    chk("full", o_full, 1'b1);
    chk("ovf_pre", o_overflow, 1'b0);
    @(posedge i_clk);
    #1;
    i_pixel_valid = 1'b1;
    i_pixel_data = 8'hAA;
    @(negedge i_clk);
    chk("drop_wr", o_lb_wr_valid, 4'b0000);
    @(posedge i_clk);
    #1;
    i_pixel_valid = 1'b0;
    @(negedge i_clk);
    chk("ovf_set", o_overflow, 1'b1);
    chk("full_hold", o_full, 1'b1);
    @(posedge i_clk);
    #1;
    i_rd_en = 1'b1;
    repeat (100) @(posedge i_clk);
    @(negedge i_clk);
    chk("ovf_sticky", o_overflow, 1'b1);
    chk("full_clr", o_full, 1'b0);
    chk("mid_read", o_window_valid, 1'b1);

    // Asynchronous reset in the middle of a READ line.
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_lb_rd", o_lb_rd, 4'b0000);
    chk("arst_wvalid", o_window_valid, 1'b0);
    chk("arst_ovf", o_overflow, 1'b0);
    chk("arst_intr", o_intr, 1'b0);
    chk("arst_full", o_full, 1'b0);
    sb.delete();
    win_in_set = 0;
    intr_due = 1'b0;
    epoch = 1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("post_rst_wv", o_window_valid, 1'b0);

    // Fresh lines after reset must start again from buffer 0.
    for (int l = 0; l < 3; l++) begin
      drive_line(l);
      repeat (20) @(posedge i_clk);
    end
    wait_drain("drain_d");
    chk("ovf_d", o_overflow, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_fetch_ctrl.md
# window_fetch_ctrl

Controller sitting directly upstream of the four 512-deep 8-bit line buffers in the processing path. It steers the incoming camera pixel stream into the buffers one line at a time, round-robin. It tracks how many buffered pixels remain unconsumed, and once three full lines are held it drives the buffers' read strobes. It assembles their 24-bit outputs into a 72-bit 3x3 window, oldest line in the top row, for the downstream kernel stage.

## Interface
- LINE_W, 512, pixels per line; must equal line-buffer depth so buffer pointers wrap on line boundaries
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset; integrator drives line-buffer i_rst from ~i_rst_n
- i_pixel_data  in  8  incoming pixel
- i_pixel_valid  in  1  pixel qualifier, at most one pixel per cycle
- o_lb_wr_data  out  8  write data to all four buffers (= i_pixel_data)
- o_lb_wr_valid  out  4  one-hot write strobe, bit n to buffer n
- i_lb0_data .. i_lb3_data  in  24 each  3-pixel outputs of buffers 0..3
- o_lb_rd  out  4  read strobes, bit n to buffer n
- i_rd_en  in  1  downstream ready; 0 stalls reading
- o_window  out  72  {top 24, mid 24, bottom 24}
- o_window_valid  out  1  o_window qualifier
- o_intr  out  1  one-cycle pulse after a full line of windows is issued
- o_full  out  1  buffered count == 4*LINE_W
- o_overflow  out  1  sticky: pixel arrived while full

## Operation
- Write side:
  - wr_cnt (9 b) counts accepted pixels in the current line; wr_sel (2 b) selects the target buffer.
  - Accepted = i_pixel_valid & ~o_full. o_lb_wr_valid = accepted ? onehot(wr_sel) : 0, combinational.
  - On an accepted pixel with wr_cnt == LINE_W-1: wr_cnt -> 0 and wr_sel -> wr_sel+1, mod 4.
- Dropped pixel (valid while full): nothing written, counters unchanged, o_overflow set until reset.
- Fill count (12 b, range 0..2048):
  - +1 on accepted write, -1 on read cycle, unchanged when both occur.
  - o_full = (fill == 2048), combinational.
- FSM states are IDLE and READ.
  - IDLE -> READ when fill >= 3*LINE_W (1536).
  - READ: a read cycle is READ & i_rd_en.
    - o_lb_rd = onehot(rd_sel) | onehot(rd_sel+1) | onehot(rd_sel+2), mod 4, during read cycles; else 0.
    - rd_cnt (9 b) increments per read cycle.
  - On the read cycle with rd_cnt == LINE_W-1: rd_cnt -> 0, rd_sel -> rd_sel+1 (mod 4), state -> IDLE, o_intr pulses the next cycle.
- Window mux (combinational): o_window = {i_lb[rd_sel], i_lb[rd_sel+1], i_lb[rd_sel+2]}; o_window_valid = READ & i_rd_en.
- The buffer being written is never among the three being read. This is guaranteed because READ requires 1536 buffered pixels and writes stop at 2048.

## Timing
- Reset (async assert, sync-safe release) sets: state IDLE, all counters and selectors 0, o_intr 0, o_overflow 0, o_lb_rd 0, o_window_valid 0.
- With i_pixel_valid low: o_lb_wr_valid 0, o_full 0.
- Write strobe has zero latency: same cycle as i_pixel_valid.
- READ entry:
  - The fill value registered at edge k satisfies the threshold, so state becomes READ at edge k+1.
  - The first window is valid in cycle k+1..k+2.
- Window has zero latency from i_rd_en; buffer outputs are combinational from read pointers.
- Minimum one IDLE cycle between consecutive lines; re-entry is immediate if fill is still >= 1536.
- i_rd_en low in READ: holds rd_cnt, rd_sel, and fill; o_lb_rd and o_window_valid are 0.
- Reset mid-line discards partial lines and in-flight windows; no o_intr is issued.

## Test plan
- Reset: assert i_rst_n=0 mid-READ -> all outputs 0 immediately (asynchronous); state IDLE after release.
- Fill: stream 1536 pixels (value = index mod 256) with i_rd_en=1 -> o_lb_wr_valid steps 0001/0010/0100 every 512 pixels; READ entered one cycle after last write.
  - o_lb_rd=0111 for 512 cycles; first o_window = {00,01,02, 00,01,02, 00,01,02}.
  - o_intr is a single pulse after the 512th window.
- Concurrent: fourth line written during the first READ -> o_lb_wr_valid=1000, fill stays 1536.
  - Second READ: o_lb_rd=1110, top row from buffer 1. Fourth READ: o_lb_rd=1011, o_window = {lb3, lb0, lb1}.
- Stall: toggle i_rd_en every cycle during READ -> window count still 512; each i_rd_en low cycle has o_window_valid=0 and o_lb_rd=0; o_intr after the 1024th cycle.
- Overflow: i_rd_en=0, write 2048 pixels -> o_full=1; 2049th pixel yields o_lb_wr_valid=0 and o_overflow=1, held until reset.
- Wrap: run 8 lines continuously with 64-cycle blanking -> rd_sel and wr_sel wrap 3->0 with correct row order, no overflow.
